// File: rtl/adc_serial_rx_mc_pkg.sv
// rtl/adc_serial_rx_mc_pkg.sv - shared state encoding and frame-length helper for the ADC serial receiver
package adc_rx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CS_SETUP = 2'd1,
    SHIFT    = 2'd2,
    QUIET    = 2'd3
  } state_t;

  // Serial clock periods per frame: leading zeros followed by the conversion bits
  function automatic int frame_len(input int lead_zeros, input int data_w);
    return lead_zeros + data_w;
  endfunction

endpackage

// File: rtl/adc_serial_rx_mc_sclk_gen.sv
// rtl/adc_serial_rx_mc_sclk_gen.sv - serial clock level and rise/fall strobes derived from SCLK_HALF
module adc_sclk_gen
  import adc_rx_pkg::*;
#(
  parameter int SCLK_HALF = 2
) (
  input  logic Clock_Nexys,
  input  logic Reset,
  input  logic en,
  output logic Clock_Muestreo,
  output logic rise,
  output logic fall
);

  localparam int            CW   = $clog2(SCLK_HALF + 1);
  localparam logic [CW-1:0] LAST = CW'(SCLK_HALF - 1);

  logic [CW-1:0] cnt;
  logic          tick;

  // Strobes announce the edge the register takes on the coming clock, so the
  // receiver can act in the same cycle the serial clock changes level.
  assign tick = (cnt == LAST);
  assign rise = tick & ~Clock_Muestreo;
  assign fall = tick & Clock_Muestreo;

  // Half-period counter; parks the serial clock high whenever disabled
  always_ff @(posedge Clock_Nexys) begin
    if (Reset || !en) begin
      cnt            <= '0;
      Clock_Muestreo <= 1'b1;
    end else if (tick) begin
      cnt            <= '0;
      Clock_Muestreo <= ~Clock_Muestreo;
    end else begin
      cnt            <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_serial_rx_mc.sv
// rtl/adc_serial_rx_mc.sv - multi-channel serial ADC receiver; optional lead-bit check via ADC_RX_ZCHK_EN
module adc_serial_rx_mc
  import adc_rx_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int LEAD_ZEROS = 4,
  parameter int CHANNELS   = 2,
  parameter int SCLK_HALF  = 2,
  parameter int QUIET_PER  = 2
) (
  input  logic                       Clock_Nexys,
  input  logic                       Reset,
  input  logic                       start,
  input  logic                       mode_cont,
  input  logic [CHANNELS-1:0]        data_ADC,
  output logic                       CS,
  output logic                       Clock_Muestreo,
  output logic                       sample_valid,
  output logic [CHANNELS*DATA_W-1:0] sample_data,
  output logic                       busy,
  output logic                       frame_err
);

  localparam int            FL     = frame_len(LEAD_ZEROS, DATA_W);
  localparam int            BW     = $clog2(FL + 1);
  localparam logic [BW-1:0] FL_B   = BW'(FL);
  localparam int            QCYC   = QUIET_PER * 2 * SCLK_HALF;
  localparam int            QW     = $clog2(QCYC + 1);
  localparam logic [QW-1:0] QCYC_B = QW'(QCYC);

  state_t                     state;
  logic [BW-1:0]              bit_cnt;
  logic [QW-1:0]              qcnt;
  logic [CHANNELS*DATA_W-1:0] shreg;
  logic                       sclk_en;
  logic                       sclk_rise;
  logic                       sclk_fall;
  logic                       last_fall;

  // The fall that would follow the final high phase instead ends the frame:
  // the generator is released so the serial clock stays parked high.
  assign last_fall = (state == SHIFT) && (bit_cnt == FL_B) && sclk_fall;
  assign sclk_en   = (state == CS_SETUP) || ((state == SHIFT) && !last_fall);

  adc_sclk_gen #(
    .SCLK_HALF(SCLK_HALF)
  ) u_sclk_gen (
    .Clock_Nexys   (Clock_Nexys),
    .Reset         (Reset),
    .en            (sclk_en),
    .Clock_Muestreo(Clock_Muestreo),
    .rise          (sclk_rise),
    .fall          (sclk_fall)
  );

  // Frame sequencer, bit counter and per-channel MSB-first shift registers.
  // Lead bits fall off the top of each DATA_W-wide register on their own.
  // QUIET spans the sample-update cycle plus QCYC cycles with CS high.
  always_ff @(posedge Clock_Nexys) begin
    if (Reset) begin
      state        <= IDLE;
      CS           <= 1'b1;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      shreg        <= '0;
      bit_cnt      <= '0;
      qcnt         <= '0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start || mode_cont) begin
            state   <= CS_SETUP;
            CS      <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= '0;
          end
        end
        CS_SETUP: begin
          if (sclk_fall) state <= SHIFT;
        end
        SHIFT: begin
          if (sclk_rise) begin
            bit_cnt <= bit_cnt + 1'b1;
            for (int i = 0; i < CHANNELS; i++)
              shreg[i*DATA_W +: DATA_W] <= {shreg[i*DATA_W +: DATA_W-1], data_ADC[i]};
          end
          if (last_fall) begin
            state        <= QUIET;
            CS           <= 1'b1;
            sample_valid <= 1'b1;
            sample_data  <= shreg;
            qcnt         <= '0;
          end
        end
        QUIET: begin
          if (qcnt == QCYC_B) begin
            if (start || mode_cont) begin
              state   <= CS_SETUP;
              CS      <= 1'b0;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            qcnt <= qcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADC_RX_ZCHK_EN
  localparam logic [BW-1:0] LZ_B = BW'(LEAD_ZEROS);

  logic lead_err;
  logic frame_err_q;

  // Accumulate any 1 seen on a lead bit; report it alongside sample_valid
  always_ff @(posedge Clock_Nexys) begin
    if (Reset) begin
      lead_err    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= last_fall ? lead_err : 1'b0;
      if (state == CS_SETUP)
        lead_err <= 1'b0;
      else if ((state == SHIFT) && sclk_rise && (bit_cnt < LZ_B) && (|data_ADC))
        lead_err <= 1'b1;
    end
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_serial_rx_mc.sv
// tb/tb_adc_serial_rx_mc.sv - scoreboard bench for adc_serial_rx_mc (default and 16-bit/4-channel builds)
module tb_adc_serial_rx_mc;

  logic Clock_Nexys = 1'b0;
  always #5 Clock_Nexys = ~Clock_Nexys;

  logic        Reset, start_a, mode_a, start_b;
  logic [1:0]  data_a;
  logic [3:0]  data_b;
  logic        cs_a, sclk_a, sv_a, busy_a, err_a;
  logic [23:0] sd_a;
  logic        cs_b, sclk_b, sv_b, busy_b, err_b;
  logic [63:0] sd_b;

  adc_serial_rx_mc #(
    .DATA_W(12), .LEAD_ZEROS(4), .CHANNELS(2), .SCLK_HALF(2), .QUIET_PER(2)
  ) dut_a (
    .Clock_Nexys(Clock_Nexys), .Reset(Reset), .start(start_a), .mode_cont(mode_a),
    .data_ADC(data_a), .CS(cs_a), .Clock_Muestreo(sclk_a), .sample_valid(sv_a),
    .sample_data(sd_a), .busy(busy_a), .frame_err(err_a)
  );

  adc_serial_rx_mc #(
    .DATA_W(16), .LEAD_ZEROS(0), .CHANNELS(4), .SCLK_HALF(1), .QUIET_PER(2)
  ) dut_b (
    .Clock_Nexys(Clock_Nexys), .Reset(Reset), .start(start_b), .mode_cont(1'b0),
    .data_ADC(data_b), .CS(cs_b), .Clock_Muestreo(sclk_b), .sample_valid(sv_b),
    .sample_data(sd_b), .busy(busy_b), .frame_err(err_b)
  );

  int cyc = 0;
  always @(posedge Clock_Nexys) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serial frame images, MSB (first transmitted bit) at index 15
  logic [15:0] frame_a [2];
  logic [15:0] frame_b [4];

  // ADC models: bit k of a frame appears after the k-th serial clock fall
  initial begin
    int  nf_a, nf_b;
    logic pa, pb;
    nf_a = 0; nf_b = 0; pa = 1'b1; pb = 1'b1;
    forever begin
      @(negedge Clock_Nexys);
      if (cs_a !== 1'b0) nf_a = 0;
      else if (pa && !sclk_a) nf_a++;
      pa = sclk_a;
      for (int c = 0; c < 2; c++)
        data_a[c] = (nf_a >= 1 && nf_a <= 16) ? frame_a[c][16-nf_a] : 1'b0;
      if (cs_b !== 1'b0) nf_b = 0;
      else if (pb && !sclk_b) nf_b++;
      pb = sclk_b;
      for (int c = 0; c < 4; c++)
        data_b[c] = (nf_b >= 1 && nf_b <= 16) ? frame_b[c][16-nf_b] : 1'b0;
    end
  end

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   vcnt_a = 0;
  int   vcnt_b = 0;

  // Monitors: pop the scoreboard whenever a DUT presents sample_valid
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock_Nexys);
      if (sv_a === 1'b1) begin
        vcnt_a++;
        if (q_a.size() == 0) check("unexpected_valid_a", 64'(sv_a), 64'd0);
        else begin
          e = q_a.pop_front();
          check("data_a", 64'(sd_a), e.data);
          check("err_a", 64'(err_a), 64'(e.err));
          check("latency_a", 64'(cyc), 64'(e.cyc));
        end
      end
      if (sv_b === 1'b1) begin
        vcnt_b++;
        if (q_b.size() == 0) check("unexpected_valid_b", 64'(sv_b), 64'd0);
        else begin
          e = q_b.pop_front();
          check("data_b", sd_b, e.data);
          check("err_b", 64'(err_b), 64'(e.err));
          check("latency_b", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic wait_valid_a(input string name, input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      @(negedge Clock_Nexys);
      if (sv_a === 1'b1) break;
    end
    if (i == bound) check(name, 64'(sv_a), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  logic lead_err_exp;

  initial begin
    int   t, nr, v0;
    logic prev;
`ifdef ADC_RX_ZCHK_EN
    lead_err_exp = 1'b1;
`else
    lead_err_exp = 1'b0;
`endif
    Reset = 1'b1; start_a = 1'b0; mode_a = 1'b0; start_b = 1'b0;
    frame_a[0] = '0; frame_a[1] = '0;
    for (int c = 0; c < 4; c++) frame_b[c] = '0;
    repeat (3) @(negedge Clock_Nexys);
    check("rst_cs", 64'(cs_a), 64'd1);
    check("rst_sclk", 64'(sclk_a), 64'd1);
    check("rst_valid", 64'(sv_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_err", 64'(err_a), 64'd0);
    check("rst_data", 64'(sd_a), 64'd0);
    check("rst_cs_b", 64'(cs_b), 64'd1);
    Reset = 1'b0;
    repeat (2) @(negedge Clock_Nexys);

    // Single frame, default parameters
    frame_a[0] = {4'h0, 12'hA5C};
    frame_a[1] = {4'h0, 12'h3F1};
    start_a = 1'b1; t = cyc;
    q_a.push_back('{64'h3F1A5C, 1'b0, t + 67});
    @(negedge Clock_Nexys); start_a = 1'b0;
    check("busy_in_frame", 64'(busy_a), 64'd1);
    repeat (80) @(negedge Clock_Nexys);
    check("single_idle_busy", 64'(busy_a), 64'd0);
    check("single_idle_cs", 64'(cs_a), 64'd1);
    check("single_count", 64'(vcnt_a), 64'd1);

    // Continuous mode: three frames 75 cycles apart, cleared mid third frame
    frame_a[0] = {4'h0, 12'h123};
    frame_a[1] = {4'h0, 12'h456};
    mode_a = 1'b1; t = cyc;
    q_a.push_back('{64'h456123, 1'b0, t + 67});
    q_a.push_back('{64'h000FFF, 1'b0, t + 142});
    q_a.push_back('{64'h001800, 1'b0, t + 217});
    wait_valid_a("cont_wait1", 100);
    check("cont_cs_high1", 64'(cs_a), 64'd1);
    frame_a[0] = {4'h0, 12'hFFF};
    frame_a[1] = {4'h0, 12'h000};
    wait_valid_a("cont_wait2", 100);
    check("cont_cs_high2", 64'(cs_a), 64'd1);
    frame_a[0] = {4'h0, 12'h800};
    frame_a[1] = {4'h0, 12'h001};
    repeat (20) @(negedge Clock_Nexys);
    mode_a = 1'b0;
    check("cont_busy_after_clear", 64'(busy_a), 64'd1);
    repeat (120) @(negedge Clock_Nexys);
    check("cont_count", 64'(vcnt_a), 64'd4);
    check("cont_idle_busy", 64'(busy_a), 64'd0);

    // start pulsed during SHIFT must not add a frame
    frame_a[0] = {4'h0, 12'h5A5};
    frame_a[1] = {4'h0, 12'hA5A};
    v0 = vcnt_a;
    start_a = 1'b1; t = cyc;
    q_a.push_back('{64'hA5A5A5, 1'b0, t + 67});
    @(negedge Clock_Nexys); start_a = 1'b0;
    repeat (30) @(negedge Clock_Nexys);
    start_a = 1'b1;
    @(negedge Clock_Nexys); start_a = 1'b0;
    repeat (150) @(negedge Clock_Nexys);
    check("shift_start_count", 64'(vcnt_a - v0), 64'd1);
    check("shift_start_idle", 64'(busy_a), 64'd0);

    // Lead bit 2 on channel 1 set to 1
    frame_a[0] = {4'h0, 12'h0F0};
    frame_a[1] = {4'b0010, 12'h70E};
    start_a = 1'b1; t = cyc;
    q_a.push_back('{64'h70E0F0, lead_err_exp, t + 67});
    @(negedge Clock_Nexys); start_a = 1'b0;
    repeat (80) @(negedge Clock_Nexys);

    // Reset at the 10th serial clock rise aborts the frame
    frame_a[0] = {4'h0, 12'hFFF};
    frame_a[1] = {4'h0, 12'hFFF};
    start_a = 1'b1;
    @(negedge Clock_Nexys); start_a = 1'b0;
    prev = sclk_a; nr = 0;
    for (int i = 0; i < 200 && nr < 10; i++) begin
      @(negedge Clock_Nexys);
      if (!prev && sclk_a) nr++;
      prev = sclk_a;
    end
    check("abort_rises", 64'(nr), 64'd10);
    check("abort_pre_cs", 64'(cs_a), 64'd0);
    Reset = 1'b1;
    @(negedge Clock_Nexys); Reset = 1'b0;
    check("abort_cs", 64'(cs_a), 64'd1);
    check("abort_sclk", 64'(sclk_a), 64'd1);
    check("abort_data", 64'(sd_a), 64'd0);
    check("abort_busy", 64'(busy_a), 64'd0);
    v0 = vcnt_a;
    repeat (100) @(negedge Clock_Nexys);
    check("abort_no_valid", 64'(vcnt_a - v0), 64'd0);

    // 16-bit, no lead bits, four channels, one-cycle half period
    frame_b[0] = 16'hFFFF; frame_b[1] = 16'h0000;
    frame_b[2] = 16'h8001; frame_b[3] = 16'h7FFE;
    start_b = 1'b1; t = cyc;
    q_b.push_back('{64'h7FFE_8001_0000_FFFF, 1'b0, t + 34});
    @(negedge Clock_Nexys); start_b = 1'b0;
    repeat (50) @(negedge Clock_Nexys);
    check("b_count", 64'(vcnt_b), 64'd1);
    check("b_idle_busy", 64'(busy_b), 64'd0);

    check("a_queue_drained", 64'(q_a.size()), 64'd0);
    check("b_queue_drained", 64'(q_b.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
